// File: rtl/useq_sequencer.sv
// useq_sequencer: runtime-loadable microcode sequencer driving datapath control lines
// Ports:
//   clk, reset (async, active-low)
//   opcode, func3, cond, trap, mem_ready  : decode/handshake inputs
//   uc_we, uc_sel, uc_row, uc_step, uc_data : microcode table write port
//   control_lines, step, instret, seq_overflow : sequencer outputs
module useq_sequencer #(
    parameter int CTRL_W = 32,
    parameter int OPC_W = 5,
    parameter int STEPS = 8,
    parameter logic [CTRL_W-1:0] FETCH_WORD = 32'h0000_0045,
    parameter int CNT_W = 64,
    localparam int SW = $clog2(STEPS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [2:0]        func3,
    input  logic              cond,
    input  logic              trap,
    input  logic              mem_ready,
    input  logic              uc_we,
    input  logic              uc_sel,
    input  logic [OPC_W-1:0]  uc_row,
    input  logic [SW-1:0]     uc_step,
    input  logic [CTRL_W-1:0] uc_data,
    output logic [CTRL_W-1:0] control_lines,
    output logic [SW-1:0]     step,
    output logic [CNT_W-1:0]  instret,
    output logic              seq_overflow
);
    logic [CTRL_W-1:0] main_tbl [2**OPC_W][STEPS];
    logic [CTRL_W-1:0] sub_tbl [8][STEPS];
    logic [CTRL_W-1:0] main_w, word;
    logic [SW-1:0] step_nxt;
    logic zero, f_inc, f_rst, f_cond, f_wait, stall, adv, wrap, retire;
    always_comb begin
        main_w = main_tbl[opcode][step];
        zero = step == '0;
        word = zero ? FETCH_WORD : main_w[CTRL_W-4] ? main_w | sub_tbl[func3][step] : main_w;
        control_lines = trap ? '0 : word;
        // step 0 behaves as a bare STEP_INC regardless of FETCH_WORD's upper bits
        f_inc = zero | word[CTRL_W-1];
        f_rst = !zero & word[CTRL_W-2];
        f_cond = !zero & word[CTRL_W-3];
        f_wait = !zero & word[CTRL_W-5];
        stall = f_wait & !mem_ready;
        adv = !trap & !stall & (f_cond ? cond : !f_rst & f_inc);
        step_nxt = (trap | (!stall & (f_cond ? !cond : f_rst))) ? '0 : adv ? step + SW'(1) : step;
        wrap = adv & (step == SW'(STEPS - 1));
        retire = !zero & !trap & !wrap & (step_nxt == '0);
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            step <= '0;
            instret <= '0;
            seq_overflow <= 1'b0;
        end else begin
            step <= step_nxt;
            instret <= instret + CNT_W'(retire);
            seq_overflow <= wrap;
        end
    // tables sit outside the reset domain so microcode survives a sequencer reset
    always_ff @(posedge clk)
        if (uc_we) begin
            if (uc_sel)
                sub_tbl[uc_row[2:0]][uc_step] <= uc_data;
            else if (uc_step != '0)
                main_tbl[uc_row][uc_step] <= uc_data;
        end
endmodule

// File: tb/tb_useq_sequencer.sv
// tb_useq_sequencer: scoreboard bench comparing useq_sequencer against a behavioural model
module tb_useq_sequencer;
    logic clk = 0;
    logic reset, cond, trap, mem_ready, uc_we, uc_sel;
    logic [4:0] opcode, uc_row;
    logic [2:0] func3, uc_step;
    logic [31:0] uc_data, control_lines;
    logic [2:0] step;
    logic [63:0] instret;
    logic seq_overflow;
    logic n_reset, n_cond, n_trap, n_mem_ready, n_we, n_sel;
    logic [4:0] n_opcode, n_row;
    logic [2:0] n_func3, n_ustep;
    logic [31:0] n_data;
    typedef struct {logic [31:0] c; int s; logic [63:0] i; bit o;} exp_t;
    exp_t q[$];
    logic [31:0] mm [32][8];
    logic [31:0] ms [8][8];
    int mst;
    logic [63:0] mins;
    bit movf;
    int checks = 0, failures = 0;
    always #5 clk = ~clk;
    useq_sequencer dut (
        .clk(clk), .reset(reset), .opcode(opcode), .func3(func3), .cond(cond), .trap(trap),
        .mem_ready(mem_ready), .uc_we(uc_we), .uc_sel(uc_sel), .uc_row(uc_row), .uc_step(uc_step),
        .uc_data(uc_data), .control_lines(control_lines), .step(step), .instret(instret),
        .seq_overflow(seq_overflow)
    );
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask
    task automatic model();
        logic [31:0] w;
        int nxt;
        bit adv, ov;
        if (!reset) begin
            mst = 0;
            mins = 0;
            movf = 0;
        end
        if (mst == 0) w = 32'h45;
        else begin
            w = mm[opcode][mst];
            if (w[28]) w = w | ms[func3][mst];
        end
        q.push_back('{trap ? 32'h0 : w, mst, mins, movf});
        if (!reset) return;
        nxt = mst;
        adv = 0;
        ov = 0;
        if (trap) nxt = 0;
        else if (mst != 0 && w[27] && !mem_ready) nxt = mst;
        else if (mst == 0) adv = 1;
        else if (w[29]) begin
            if (cond) adv = 1;
            else nxt = 0;
        end else if (w[30]) nxt = 0;
        else if (w[31]) adv = 1;
        if (adv) begin
            if (mst == 7) begin
                nxt = 0;
                ov = 1;
            end else nxt = mst + 1;
        end
        if (mst != 0 && nxt == 0 && !trap && !ov) mins++;
        mst = nxt;
        movf = ov;
        if (uc_we) begin
            if (uc_sel) ms[uc_row[2:0]][uc_step] = uc_data;
            else if (uc_step != 0) mm[uc_row][uc_step] = uc_data;
        end
    endtask
    task automatic cyc();
        @(negedge clk);
        reset = n_reset;
        opcode = n_opcode;
        func3 = n_func3;
        cond = n_cond;
        trap = n_trap;
        mem_ready = n_mem_ready;
        uc_we = n_we;
        uc_sel = n_sel;
        uc_row = n_row;
        uc_step = n_ustep;
        uc_data = n_data;
        model();
    endtask
    task automatic wr(input bit sel, input int row, input int st, input logic [31:0] d);
        n_we = 1;
        n_sel = sel;
        n_row = 5'(row);
        n_ustep = 3'(st);
        n_data = d;
        cyc();
        n_we = 0;
    endtask
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("control_lines", 64'(control_lines), 64'(e.c));
                chk("step", 64'(step), 64'(e.s));
                chk("instret", instret, e.i);
                chk("seq_overflow", 64'(seq_overflow), 64'(e.o));
            end
        end
    end
    initial begin
        for (int r = 0; r < 32; r++) for (int s = 0; s < 8; s++) mm[r][s] = 0;
        for (int r = 0; r < 8; r++) for (int s = 0; s < 8; s++) ms[r][s] = 0;
        mst = 0;
        mins = 0;
        movf = 0;
        {reset, cond, trap, mem_ready, uc_we, uc_sel, opcode, uc_row, func3, uc_step, uc_data} = '0;
        {n_cond, n_we, n_sel, n_opcode, n_row, n_func3, n_ustep, n_data} = '0;
        n_reset = 0;
        n_trap = 1;
        n_mem_ready = 1;
        repeat (2) cyc();
        n_reset = 1;
        for (int r = 0; r < 32; r++) for (int s = 1; s < 8; s++) wr(0, r, s, 0);
        for (int r = 0; r < 8; r++) for (int s = 0; s < 8; s++) wr(1, r, s, 0);
        wr(0, 13, 1, 32'h4000_0200);
        for (int s = 1; s < 8; s++) wr(0, 4, s, 32'h8000_0000);
        wr(0, 0, 1, 32'h8800_0040);
        wr(0, 0, 2, 32'h4000_0000);
        wr(0, 24, 1, 32'h2000_0001);
        wr(0, 24, 2, 32'h4000_0000);
        wr(0, 28, 1, 32'h1000_0010);
        wr(1, 3, 1, 32'h100);
        wr(1, 4, 1, 32'h0);
        wr(0, 6, 1, 32'h8000_0000);
        wr(0, 6, 2, 32'h8800_0000);
        n_trap = 0;
        n_opcode = 4;
        repeat (4) cyc();
        #3 chk("mid_step", 64'(step), 3);
        n_reset = 0;
        cyc();
        #3 chk("async_reset_step", 64'(step), 0);
        chk("async_reset_instret", instret, 0);
        n_reset = 1;
        n_opcode = 13;
        cyc();
        #3 chk("fetch_word", 64'(control_lines), 64'h45);
        cyc();
        #3 chk("step1_word", 64'(control_lines), 64'h4000_0200);
        n_trap = 1;
        cyc();
        #3 chk("first_retire", instret, 1);
        n_trap = 0;
        n_opcode = 0;
        n_mem_ready = 0;
        cyc();
        repeat (3) begin
            cyc();
            #3 chk("wait_hold", 64'(step), 1);
        end
        n_mem_ready = 1;
        cyc();
        cyc();
        #3 chk("wait_release", 64'(step), 2);
        n_trap = 1;
        cyc();
        #3 chk("wait_retire", instret, 2);
        n_trap = 0;
        n_opcode = 24;
        n_cond = 0;
        cyc();
        cyc();
        n_trap = 1;
        cyc();
        #3 chk("cond_false_retire", instret, 3);
        n_trap = 0;
        n_cond = 1;
        cyc();
        cyc();
        cyc();
        #3 chk("cond_true_step", 64'(step), 2);
        n_trap = 1;
        cyc();
        n_trap = 0;
        n_opcode = 28;
        n_func3 = 3;
        cyc();
        cyc();
        #3 chk("sub_merge3", 64'(control_lines), 64'h1000_0110);
        n_func3 = 4;
        cyc();
        #3 chk("sub_merge4", 64'(control_lines), 64'h1000_0010);
        n_trap = 1;
        cyc();
        n_trap = 0;
        n_opcode = 4;
        repeat (8) cyc();
        n_trap = 1;
        cyc();
        #3 chk("ovf_pulse", 64'(seq_overflow), 1);
        chk("ovf_no_retire", instret, 4);
        cyc();
        #3 chk("ovf_clear", 64'(seq_overflow), 0);
        n_trap = 0;
        n_opcode = 6;
        n_mem_ready = 0;
        cyc();
        cyc();
        n_trap = 1;
        cyc();
        #3 chk("trap_ctrl", 64'(control_lines), 0);
        cyc();
        #3 chk("trap_step", 64'(step), 0);
        wr(0, 5, 0, 32'hFFFF_FFFF);
        n_trap = 0;
        n_opcode = 5;
        n_mem_ready = 1;
        cyc();
        #3 chk("step0_write_ignored", 64'(control_lines), 64'h45);
        n_trap = 1;
        cyc();
        repeat (3000) begin
            n_reset = $urandom_range(0, 199) != 0;
            n_trap = $urandom_range(0, 19) == 0;
            n_mem_ready = $urandom_range(0, 3) != 0;
            n_cond = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) n_opcode = 5'($urandom);
            if ($urandom_range(0, 4) == 0) n_func3 = 3'($urandom);
            n_we = n_reset && $urandom_range(0, 7) == 0;
            n_sel = 1'($urandom_range(0, 1));
            n_row = 5'($urandom);
            n_ustep = 3'($urandom);
            n_data = n_sel ? {5'b0, 27'($urandom)} : $urandom;
            cyc();
        end
        n_reset = 1;
        n_we = 0;
        n_trap = 1;
        repeat (3) cyc();
        repeat (3) @(negedge clk);
        if (q.size() != 0) chk("scoreboard_drained", 64'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
